riscv_hwloop_unit: RTL and testbench
====================================

# riscv_hwloop_unit

Parametrised hardware-loop unit for the RI5CY core. Holds start/end/count registers for N_REGS nestable hardware loops and compares the current instruction address against every loop end. It resolves nested-loop priority, generates the jump request and target, and decrements counters internally on retirement. It sits between the EX-stage loop-setup path and the fetch/ID jump path, and replaces the separate register file plus external decrement-select logic.

## Interface
- N_REGS, 2, number of loop register sets; index 0 is the innermost loop, N_REGS-1 the outermost.
- N_REG_BITS, $clog2(N_REGS) (minimum 1), width of the register-set index.
- ADDR_WIDTH, 32, width of start/end addresses and of pc_i.
- CNT_WIDTH, 32, width of the iteration counters.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hwlp_start_data_i  in  ADDR_WIDTH  start-address write data.
- hwlp_end_data_i  in  ADDR_WIDTH  end-address write data.
- hwlp_cnt_data_i  in  CNT_WIDTH  counter write data.
- hwlp_we_i  in  3  write enables: bit0 start, bit1 end, bit2 counter.
- hwlp_regid_i  in  N_REG_BITS  target set for writes.
- pc_i  in  ADDR_WIDTH  address of the instruction currently in ID.
- valid_i  in  1  the instruction at pc_i retires this cycle.
- hwlp_jump_o  out  1  redirect fetch to hwlp_target_o.
- hwlp_target_o  out  ADDR_WIDTH  jump target.
- hwlp_active_o  out  N_REGS  counter of set k is non-zero.
- hwlp_done_o  out  N_REGS  registered one-cycle pulse; loop k finished.
- hwlp_start_addr_o / hwlp_end_addr_o  out  N_REGS x ADDR_WIDTH  register contents.
- hwlp_counter_o  out  N_REGS x CNT_WIDTH  register contents.

## Operation
- Registers: start_q[k], end_q[k], cnt_q[k], done_q[k]. All reset to 0, so every output is 0 in reset.
- active[k] = (cnt_q[k] != 0).
- match[k] = active[k] && (pc_i == end_q[k]).
- Selection: j = lowest k with match[k] && cnt_q[k] > 1. "j exists" means at least one such k.
- hwlp_jump_o = valid_i && j exists. hwlp_target_o = start_q[j] when j exists, else 0. Both are combinational.
- Decrement set D, evaluated only when valid_i = 1:
  - If j exists, D = all matching k with k <= j. Inner loops below j sit at their last iteration and go from 1 to 0.
  - If no j exists, D = all matching k; every one of them goes from 1 to 0.
  - Loops with index above j are never decremented.
- Decrement arithmetic: cnt_q[k] <= cnt_q[k] - 1 for k in D. A counter in D is always at least 1, so it cannot underflow.
- Writes, at the clock edge:
  - For each bit of hwlp_we_i, write the matching register of set hwlp_regid_i.
  - If hwlp_regid_i >= N_REGS, the write is ignored entirely.
  - The three bits are independent and may be asserted together.
- Same-cycle conflict: a counter write to set k overrides a decrement of set k. Other sets in D still decrement.
- A counter write of 0 deactivates the loop.
- done_q[k] <= (k in D) && cnt_q[k] == 1 && no counter write to k this cycle. It is cleared on every other cycle.
- valid_i = 0 stalls the unit: counters hold, jump_o = 0, done_q clears.

## Timing
- Setup write latency is 1 cycle: a value written at edge t is used for match and target from cycle t+1.
- Jump/target have zero latency from pc_i, valid_i and the registered state.
- A counter update is visible on hwlp_counter_o 1 cycle after the retiring valid_i.
- hwlp_done_o is high exactly the cycle after the final retirement.
- Reset asserted mid-loop clears all registers immediately (asynchronous). The first post-reset cycle has no active loops and no jump.
- Boundary conditions:
  - Loops that share an end address are handled by the nesting rule above.
  - Equal end address but inactive (count 0) gives no match.
  - A counter at its maximum value (2^CNT_WIDTH - 1) decrements normally; there is no wrap.

## Test plan
- Single loop: write set 0 with start 0x100, end 0x10C, count 3. Retire at pc 0x10C three times. Required: jump to 0x100 on retirements 1 and 2 with count 3→2→1; no jump on the 3rd, count 1→0; done_o[0] pulses in the next cycle; active_o[0] drops.
- Nested loops with shared end: set0 count 1, set1 count 4, both end 0x200, set1 start 0x1F0. Retire at 0x200. Required: jump to 0x1F0; cnt0 1→0; cnt1 4→3; done_o = 2'b01.
- Stall: match with count 5 and valid_i = 0 for 3 cycles. Required: jump_o = 0 and count stays 5; on valid_i = 1, count becomes 4.
- Write/decrement collision: set0 count 2 retiring at its end while we_i = 3'b100, regid 0, data 7. Required: count becomes 7 (not 1), no done pulse, jump_o = 1 this cycle.
- Inactive match: end 0x300 with count 0 and pc 0x300 retiring. Required: no jump and no counter change. Then write count 0 to an active loop; required: active_o drops the next cycle.
- Reset: assert rst_n low mid-loop with count 9. Required: all outputs 0 immediately, and no jump after release.

Source files
------------

// File: rtl/riscv_hwloop_unit.sv
// riscv_hwloop_unit
// Hardware-loop unit for the RI5CY core. Holds start/end/count registers for
// N_REGS nestable loops (set 0 innermost), matches the ID-stage pc against every
// loop end, resolves nesting priority, and produces the fetch jump request and
// target. Loop counters are decremented here when the instruction retires.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   hwlp_start_data_i     start-address write data
//   hwlp_end_data_i       end-address write data
//   hwlp_cnt_data_i       counter write data
//   hwlp_we_i             write enables {cnt, end, start}
//   hwlp_regid_i          target register set for writes
//   pc_i                  address of the instruction in ID
//   valid_i               instruction at pc_i retires this cycle
//   hwlp_jump_o           redirect fetch to hwlp_target_o (combinational)
//   hwlp_target_o         jump target (combinational)
//   hwlp_active_o         per-set counter non-zero
//   hwlp_done_o           per-set one-cycle pulse after the final retirement
//   hwlp_start_addr_o     start register contents
//   hwlp_end_addr_o       end register contents
//   hwlp_counter_o        counter register contents
module riscv_hwloop_unit #(
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                hwlp_start_data_i,
    input  logic [ADDR_WIDTH-1:0]                hwlp_end_data_i,
    input  logic [CNT_WIDTH-1:0]                 hwlp_cnt_data_i,
    input  logic [2:0]                           hwlp_we_i,
    input  logic [N_REG_BITS-1:0]                hwlp_regid_i,
    input  logic [ADDR_WIDTH-1:0]                pc_i,
    input  logic                                 valid_i,
    output logic                                 hwlp_jump_o,
    output logic [ADDR_WIDTH-1:0]                hwlp_target_o,
    output logic [N_REGS-1:0]                    hwlp_active_o,
    output logic [N_REGS-1:0]                    hwlp_done_o,
    output logic [N_REGS-1:0][ADDR_WIDTH-1:0]    hwlp_start_addr_o,
    output logic [N_REGS-1:0][ADDR_WIDTH-1:0]    hwlp_end_addr_o,
    output logic [N_REGS-1:0][CNT_WIDTH-1:0]     hwlp_counter_o
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [N_REGS-1:0][ADDR_WIDTH-1:0] start_q, start_d;
    logic [N_REGS-1:0][ADDR_WIDTH-1:0] end_q, end_d;
    logic [N_REGS-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [N_REGS-1:0]                 done_q, done_d;

    logic [N_REGS-1:0] active;
    logic [N_REGS-1:0] match;
    logic [N_REGS-1:0] dec;
    logic [N_REGS-1:0] set_sel;
    logic              j_found;
    int unsigned       j_idx;
    logic              regid_ok;

    // Widen by one bit so an out-of-range id is representable for any N_REGS.
    assign regid_ok = {1'b0, hwlp_regid_i} < (N_REG_BITS + 1)'(N_REGS);

    // Match and nested-loop selection: j is the innermost matching loop that
    // still has iterations left after this one.
    always_comb begin
        j_found       = 1'b0;
        j_idx         = 0;
        hwlp_target_o = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            active[k] = (cnt_q[k] != '0);
            match[k]  = active[k] && (pc_i == end_q[k]);
            if (!j_found && match[k] && (cnt_q[k] > CntOne)) begin
                j_found       = 1'b1;
                j_idx         = k;
                hwlp_target_o = start_q[k];
            end
        end
    end

    assign hwlp_jump_o = valid_i && j_found;

    // Next-state: writes win over decrements; loops outside j are left alone.
    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        for (int unsigned k = 0; k < N_REGS; k++) begin
            set_sel[k] = regid_ok && (hwlp_regid_i == N_REG_BITS'(k));
            dec[k]     = valid_i && match[k] && (!j_found || (k <= j_idx));
            if (set_sel[k] && hwlp_we_i[0]) start_d[k] = hwlp_start_data_i;
            if (set_sel[k] && hwlp_we_i[1]) end_d[k]   = hwlp_end_data_i;
            if (set_sel[k] && hwlp_we_i[2]) begin
                cnt_d[k] = hwlp_cnt_data_i;
            end else if (dec[k]) begin
                cnt_d[k]  = cnt_q[k] - CntOne;
                done_d[k] = (cnt_q[k] == CntOne);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign hwlp_active_o     = active;
    assign hwlp_done_o       = done_q;
    assign hwlp_start_addr_o = start_q;
    assign hwlp_end_addr_o   = end_q;
    assign hwlp_counter_o    = cnt_q;

endmodule

// File: tb/tb_riscv_hwloop_unit.sv
// Directed self-checking bench for riscv_hwloop_unit (N_REGS = 2, 32-bit).
module tb_riscv_hwloop_unit;

    logic             clk;
    logic             rst_n;
    logic [31:0]      start_data;
    logic [31:0]      end_data;
    logic [31:0]      cnt_data;
    logic [2:0]       we;
    logic [0:0]       regid;
    logic [31:0]      pc;
    logic             valid;
    logic             jump;
    logic [31:0]      target;
    logic [1:0]       active;
    logic [1:0]       done;
    logic [1:0][31:0] start_addr;
    logic [1:0][31:0] end_addr;
    logic [1:0][31:0] counter;

    int checks   = 0;
    int failures = 0;

    riscv_hwloop_unit #(
        .N_REGS     (2),
        .ADDR_WIDTH (32),
        .CNT_WIDTH  (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hwlp_start_data_i (start_data),
        .hwlp_end_data_i   (end_data),
        .hwlp_cnt_data_i   (cnt_data),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .pc_i              (pc),
        .valid_i           (valid),
        .hwlp_jump_o       (jump),
        .hwlp_target_o     (target),
        .hwlp_active_o     (active),
        .hwlp_done_o       (done),
        .hwlp_start_addr_o (start_addr),
        .hwlp_end_addr_o   (end_addr),
        .hwlp_counter_o    (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; registered state is
    // sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [0:0] id, input logic [2:0] w, input logic [31:0] s,
                      input logic [31:0] e, input logic [31:0] c);
        regid      = id;
        we         = w;
        start_data = s;
        end_data   = e;
        cnt_data   = c;
        tick();
        we = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0; start_data = '0; end_data = '0; cnt_data = '0;
        we = '0; regid = '0; pc = '0; valid = 1'b0;
        #3;
        chk("rst_jump", 64'(jump), 64'h0);
        chk("rst_active", 64'(active), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_cnt0", 64'(counter[0]), 64'h0);
        #4 rst_n = 1'b1;
        tick();

        // Single loop, three iterations.
        wr(1'b0, 3'b111, 32'h100, 32'h10C, 32'd3);
        chk("s_cnt_init", 64'(counter[0]), 64'd3);
        chk("s_active", 64'(active), 64'h1);
        pc = 32'h10C; valid = 1'b1;
        #1;
        chk("s_jump1", 64'(jump), 64'h1);
        chk("s_tgt1", 64'(target), 64'h100);
        tick();
        chk("s_cnt2", 64'(counter[0]), 64'd2);
        chk("s_jump2", 64'(jump), 64'h1);
        tick();
        chk("s_cnt1", 64'(counter[0]), 64'd1);
        chk("s_done_early", 64'(done), 64'h0);
        chk("s_jump3", 64'(jump), 64'h0);
        chk("s_tgt3", 64'(target), 64'h0);
        tick();
        valid = 1'b0;
        chk("s_cnt0", 64'(counter[0]), 64'd0);
        chk("s_done", 64'(done), 64'h1);
        chk("s_inactive", 64'(active), 64'h0);
        tick();
        chk("s_done_clr", 64'(done), 64'h0);

        // Nested loops sharing an end address.
        wr(1'b0, 3'b111, 32'h1E0, 32'h200, 32'd1);
        wr(1'b1, 3'b111, 32'h1F0, 32'h200, 32'd4);
        pc = 32'h200; valid = 1'b1;
        #1;
        chk("n_jump", 64'(jump), 64'h1);
        chk("n_tgt", 64'(target), 64'h1F0);
        tick();
        valid = 1'b0;
        chk("n_cnt0", 64'(counter[0]), 64'd0);
        chk("n_cnt1", 64'(counter[1]), 64'd3);
        chk("n_done", 64'(done), 64'h1);

        // Stall with a matching loop.
        wr(1'b0, 3'b111, 32'h400, 32'h410, 32'd5);
        pc = 32'h410;
        for (int i = 0; i < 3; i++) begin
            chk("st_jump", 64'(jump), 64'h0);
            tick();
            chk("st_cnt", 64'(counter[0]), 64'd5);
        end
        chk("st_done", 64'(done), 64'h0);
        valid = 1'b1;
        #1;
        chk("st_jump_go", 64'(jump), 64'h1);
        chk("st_tgt_go", 64'(target), 64'h400);
        tick();
        valid = 1'b0;
        chk("st_cnt4", 64'(counter[0]), 64'd4);

        // Counter write collides with a decrement.
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd2);
        valid = 1'b1; regid = 1'b0; we = 3'b100; cnt_data = 32'd7;
        #1;
        chk("c_jump", 64'(jump), 64'h1);
        tick();
        valid = 1'b0; we = 3'b000;
        chk("c_cnt", 64'(counter[0]), 64'd7);
        chk("c_done", 64'(done), 64'h0);

        // Maximum counter decrements without wrap.
        wr(1'b0, 3'b111, 32'h4F0, 32'h500, 32'hFFFF_FFFF);
        pc = 32'h500; valid = 1'b1;
        #1;
        chk("m_jump", 64'(jump), 64'h1);
        chk("m_tgt", 64'(target), 64'h4F0);
        tick();
        valid = 1'b0;
        chk("m_cnt", 64'(counter[0]), 64'hFFFF_FFFE);

        // Inactive match, then deactivate set 1 by writing count 0.
        wr(1'b0, 3'b110, 32'h0, 32'h300, 32'd0);
        chk("i_end", 64'(end_addr[0]), 64'h300);
        chk("i_start_kept", 64'(start_addr[0]), 64'h4F0);
        pc = 32'h300; valid = 1'b1;
        #1;
        chk("i_jump", 64'(jump), 64'h0);
        tick();
        valid = 1'b0;
        chk("i_cnt0", 64'(counter[0]), 64'd0);
        chk("i_cnt1", 64'(counter[1]), 64'd3);
        chk("i_done", 64'(done), 64'h0);
        chk("i_active_pre", 64'(active), 64'h2);
        wr(1'b1, 3'b100, 32'h0, 32'h0, 32'd0);
        chk("i_active_post", 64'(active), 64'h0);

        // Asynchronous reset in the middle of a loop.
        wr(1'b0, 3'b111, 32'h600, 32'h60C, 32'd9);
        pc = 32'h60C; valid = 1'b1;
        #1;
        chk("r_jump_pre", 64'(jump), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("r_cnt", 64'(counter[0]), 64'h0);
        chk("r_start", 64'(start_addr[0]), 64'h0);
        chk("r_end", 64'(end_addr[0]), 64'h0);
        chk("r_active", 64'(active), 64'h0);
        chk("r_jump", 64'(jump), 64'h0);
        #1 rst_n = 1'b1;
        #1;
        chk("r_jump_post", 64'(jump), 64'h0);
        tick();
        valid = 1'b0;
        chk("r_cnt_post", 64'(counter[0]), 64'h0);
        chk("r_done_post", 64'(done), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
